// File: rtl/hex_scroll_display_pkg.sv
// Shared character codes, segment constants and FSM state for the scrolling
// seven-segment message display.
package hex_scroll_display_pkg;

  localparam logic [4:0] CHAR_R = 5'd16;
  localparam logic [4:0] CHAR_D = 5'd17;
  localparam logic [4:0] CHAR_T = 5'd18;
  localparam logic [4:0] BLANK  = 5'd19;

  // Segments are active-low, ordered {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_STATIC,
    ST_SCROLL
  } state_t;

endpackage

// File: rtl/hex_scroll_display_hexdriver.sv
// Single-digit decoder: 5-bit character code to active-low segment byte.
module hexDriver
  import hex_scroll_display_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:   seg = 8'hC0;
      5'd1:   seg = 8'hF9;
      5'd2:   seg = 8'hA4;
      5'd3:   seg = 8'hB0;
      5'd4:   seg = 8'h99;
      5'd5:   seg = 8'h92;
      5'd6:   seg = 8'h82;
      5'd7:   seg = 8'hF8;
      5'd8:   seg = 8'h80;
      5'd9:   seg = 8'h90;
      5'd10:  seg = 8'h88;
      5'd11:  seg = 8'h83;
      5'd12:  seg = 8'hC6;
      5'd13:  seg = 8'hA1;
      5'd14:  seg = 8'h86;
      5'd15:  seg = 8'h8E;
      CHAR_R: seg = 8'hAF;
      CHAR_D: seg = 8'hA1;
      CHAR_T: seg = 8'h87;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_display.sv
// Message buffer with static / scrolling window, step prescaler and whole-
// display blink; one registered character per digit feeding a hexDriver.
module hex_scroll_display
  import hex_scroll_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16,
  parameter int STEP_DIV   = 25_000_000,
  parameter int BLINK_DIV  = 12_500_000
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [MSG_LEN*5-1:0]         load_chars,
  input  logic [$clog2(MSG_LEN+1)-1:0] load_len,
  input  logic                         blink_en,
  input  logic                         pause,
  output logic [NUM_DIGITS*8-1:0]      hex_out,
  output logic                         scrolling,
  output logic                         wrap
);

  localparam int LW = $clog2(MSG_LEN+1);
  localparam int OW = $clog2(MSG_LEN+2*NUM_DIGITS);
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int PW = $clog2(STEP_DIV+1);
  localparam int BW = $clog2(BLINK_DIV+1);

  state_t                     state_q, state_n;
  logic [LW-1:0]              len_q, len_n, len_in;
  logic [OW-1:0]              off_q, off_n, per_n;
  logic [PW-1:0]              presc_q, presc_n;
  logic [BW-1:0]              bcnt_q, bcnt_n;
  logic                       boff_q, boff_n;
  logic                       rdy_q, wrap_q, wrap_n;
  logic [MSG_LEN-1:0][4:0]    msg_q, msg_n;
  logic                       hs, step, last;

  assign hs     = load_valid && rdy_q;
  assign len_in = (load_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : load_len;
  assign step   = (state_q == ST_SCROLL) && !pause && (presc_q == PW'(STEP_DIV-1));
  assign last   = (off_q == OW'(len_q) + OW'(NUM_DIGITS-1));

  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    msg_n   = msg_q;
    off_n   = off_q;
    presc_n = presc_q;
    wrap_n  = 1'b0;
    if (hs) begin
      msg_n   = load_chars;
      len_n   = len_in;
      off_n   = '0;
      presc_n = '0;
      if (len_in == '0)                          state_n = ST_EMPTY;
      else if (OW'(len_in) <= OW'(NUM_DIGITS))   state_n = ST_STATIC;
      else                                       state_n = ST_SCROLL;
    end else if (state_q == ST_SCROLL && !pause) begin
      presc_n = step ? '0 : presc_q + PW'(1);
      if (step) begin
        off_n  = last ? '0 : off_q + OW'(1);
        wrap_n = last;
      end
    end
  end

  always_comb begin
    bcnt_n = '0;
    boff_n = 1'b0;
    if (blink_en) begin
      bcnt_n = (bcnt_q == BW'(BLINK_DIV-1)) ? '0 : bcnt_q + BW'(1);
      boff_n = (bcnt_q == BW'(BLINK_DIV-1)) ? !boff_q : boff_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      len_q   <= '0;
      msg_q   <= {MSG_LEN{BLANK}};
      off_q   <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      boff_q  <= 1'b0;
      rdy_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      msg_q   <= msg_n;
      off_q   <= off_n;
      presc_q <= presc_n;
      bcnt_q  <= bcnt_n;
      boff_q  <= boff_n;
      rdy_q   <= 1'b1;
      wrap_q  <= wrap_n;
    end
  end

  // Window is computed from next-cycle values so the registered characters
  // track a handshake or step with no extra latency.
  assign per_n = OW'(len_n) + OW'(NUM_DIGITS);

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic [OW-1:0] sum, idx;
    logic [4:0]    ch_n, ch_q;

    always_comb begin
      sum  = off_n + OW'(NUM_DIGITS-1-d);
      idx  = (sum >= per_n) ? sum - per_n : sum;
      ch_n = BLANK;
      if (!boff_n && idx < OW'(len_n)) ch_n = msg_n[idx[IW-1:0]];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) ch_q <= BLANK;
      else        ch_q <= ch_n;
    end

    hexDriver u_hex (
      .code (ch_q),
      .seg  (hex_out[d*8 +: 8])
    );
  end

  assign load_ready = rdy_q;
  assign scrolling  = (state_q == ST_SCROLL);
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_hex_scroll_display.sv
// Table vectors, hand-written corner sequences and a randomized run, all
// scored against a cycle-count model of the scrolling display.
module tb_hex_scroll_display;

  localparam int ND = 6;
  localparam int ML = 16;
  localparam int SD = 4;
  localparam int BD = 8;
  localparam logic [47:0] ALLB = {6{8'hFF}};

  logic        clk = 1'b0;
  logic        rst_n, load_valid, load_ready, blink_en, pause, scrolling, wrap;
  logic [79:0] load_chars;
  logic [4:0]  load_len;
  logic [47:0] hex_out;

  hex_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .STEP_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_chars (load_chars),
    .load_len   (load_len),
    .blink_en   (blink_en),
    .pause      (pause),
    .hex_out    (hex_out),
    .scrolling  (scrolling),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  // Reference model: display derived from counts of elapsed cycles.
  int         mlen = 0, act = 0, bcnt = 0;
  bit         mrdy = 1'b0, mwrap = 1'b0;
  logic [4:0] msg [ML];

  function automatic logic [7:0] seg(input logic [4:0] c);
    case (c)
      5'd0: return 8'hC0;  5'd1: return 8'hF9;  5'd2: return 8'hA4;  5'd3: return 8'hB0;
      5'd4: return 8'h99;  5'd5: return 8'h92;  5'd6: return 8'h82;  5'd7: return 8'hF8;
      5'd8: return 8'h80;  5'd9: return 8'h90;  5'd10: return 8'h88; 5'd11: return 8'h83;
      5'd12: return 8'hC6; 5'd13: return 8'hA1; 5'd14: return 8'h86; 5'd15: return 8'h8E;
      5'd16: return 8'hAF; 5'd17: return 8'hA1; 5'd18: return 8'h87;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] exp_hex();
    logic [47:0] h;
    int off, j;
    off = (act / SD) % (mlen + ND);
    for (int i = 0; i < ND; i++) begin
      j = (off + i) % (mlen + ND);
      h[(ND-1-i)*8 +: 8] = (((bcnt / BD) % 2) == 1 || j >= mlen) ? 8'hFF : seg(msg[j[3:0]]);
    end
    return h;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  task automatic tick();
    bit hs;
    @(posedge clk);
    if (!rst_n) begin
      mlen = 0; act = 0; bcnt = 0; mrdy = 1'b0; mwrap = 1'b0;
    end else begin
      hs    = load_valid && mrdy;
      mrdy  = 1'b1;
      bcnt  = blink_en ? bcnt + 1 : 0;
      mwrap = 1'b0;
      if (hs) begin
        mlen = (load_len > 5'd16) ? 16 : int'(load_len);
        for (int k = 0; k < ML; k++) msg[k] = load_chars[k*5 +: 5];
        act = 0;
      end else if (mlen > ND && !pause) begin
        act++;
        mwrap = (act % (SD * (mlen + ND))) == 0;
      end
    end
    #1;
    cmp("model_hex", 64'(hex_out), 64'(exp_hex()));
    cmp("model_scrolling", 64'(scrolling), 64'(mlen > ND));
    cmp("model_wrap", 64'(wrap), 64'(mwrap));
    cmp("model_ready", 64'(load_ready), 64'(mrdy));
  endtask

  task automatic load(input logic [4:0] len, input logic [79:0] chars);
    load_valid = 1'b1; load_len = len; load_chars = chars;
    tick();
    load_valid = 1'b0;
  endtask

  function automatic logic [79:0] mk(input logic [4:0] c0, c1, c2, c3, c4, c5, c6, c7);
    return {40'd0, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic wait_wrap(input string name, input int want);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      tick(); n++;
      seen = wrap;
    end
    cmp(name, 64'(n), 64'(want));
  endtask

  typedef struct {
    logic [4:0]  len;
    logic [79:0] chars;
    logic [47:0] hex;
    logic        scr;
  } vec_t;

  vec_t tbl [9];
  logic [47:0] snap;
  logic [95:0] rnd;

  initial begin
    tbl[0] = '{5'd4,  mk(1,2,3,4,0,0,0,0),        48'hF9A4B099FFFF, 1'b0};
    tbl[1] = '{5'd0,  mk(1,2,3,4,0,0,0,0),        ALLB,             1'b0};
    tbl[2] = '{5'd6,  mk(10,11,12,13,14,15,0,0),  48'h8883C6A1868E, 1'b0};
    tbl[3] = '{5'd3,  mk(16,17,18,0,0,0,0,0),     48'hAFA187FFFFFF, 1'b0};
    tbl[4] = '{5'd2,  mk(25,5,0,0,0,0,0,0),       48'hFF92FFFFFFFF, 1'b0};
    tbl[5] = '{5'd8,  mk(0,1,2,3,4,5,6,7),        48'hC0F9A4B09992, 1'b1};
    tbl[6] = '{5'd20, mk(9,8,7,6,5,4,3,2),        48'h9080F8829299, 1'b1};
    tbl[7] = '{5'd1,  mk(19,3,3,3,3,3,3,3),       ALLB,             1'b0};
    tbl[8] = '{5'd7,  mk(8,8,8,8,8,8,0,1),        48'h808080808080, 1'b1};

    for (int k = 0; k < ML; k++) msg[k] = 5'd19;
    rst_n = 1'b0; load_valid = 1'b1; load_chars = '0; load_len = 5'd4;
    blink_en = 1'b0; pause = 1'b0;
    tick(); tick();
    cmp("reset_hex", 64'(hex_out), 64'(ALLB));
    cmp("reset_ready", 64'(load_ready), 64'd0);
    cmp("reset_scrolling", 64'(scrolling), 64'd0);
    cmp("reset_wrap", 64'(wrap), 64'd0);
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      load(tbl[v].len, tbl[v].chars);
      cmp($sformatf("vec%0d_hex", v), 64'(hex_out), 64'(tbl[v].hex));
      cmp($sformatf("vec%0d_scrolling", v), 64'(scrolling), 64'(tbl[v].scr));
      tick(); tick();
    end

    // Wrap timing for an 8-char message, then a 10-cycle pause mid-scroll.
    load(5'd8, mk(0,1,2,3,4,5,6,7));
    wait_wrap("wrap_latency", 56);
    tick();
    cmp("wrap_width", 64'(wrap), 64'd0);
    repeat (6) tick();
    snap = hex_out;
    pause = 1'b1;
    repeat (10) tick();
    cmp("pause_hold", 64'(hex_out), 64'(snap));
    pause = 1'b0;
    repeat (12) tick();

    // Handshake on an ordinary step cycle and on the wrapping step cycle.
    load(5'd8, mk(0,1,2,3,4,5,6,7));
    repeat (3) tick();
    load(5'd8, mk(0,1,2,3,4,5,6,7));
    cmp("hs_step_disp", 64'(hex_out), 64'(48'hC0F9A4B09992));
    repeat (55) tick();
    load(5'd4, mk(1,2,3,4,0,0,0,0));
    cmp("hs_wrap_nowrap", 64'(wrap), 64'd0);
    cmp("hs_wrap_disp", 64'(hex_out), 64'(48'hF9A4B099FFFF));

    // Blink on a static message.
    blink_en = 1'b1;
    repeat (8) tick();
    cmp("blink_off", 64'(hex_out), 64'(ALLB));
    repeat (8) tick();
    cmp("blink_on", 64'(hex_out), 64'(48'hF9A4B099FFFF));
    repeat (12) tick();
    blink_en = 1'b0;
    tick();
    cmp("blink_disabled", 64'(hex_out), 64'(48'hF9A4B099FFFF));
    repeat (20) tick();
    cmp("blink_steady", 64'(hex_out), 64'(48'hF9A4B099FFFF));

    // Clamped 20-char message scrolls with an 88-cycle period.
    load(5'd20, mk(9,8,7,6,5,4,3,2));
    wait_wrap("len20_first_wrap", 88);
    wait_wrap("len20_period", 88);

    // Reset mid-scroll abandons the message.
    load(5'd8, mk(0,1,2,3,4,5,6,7));
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    cmp("midreset_ready", 64'(load_ready), 64'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    cmp("midreset_empty", 64'(hex_out), 64'(ALLB));
    cmp("midreset_scrolling", 64'(scrolling), 64'd0);

    // Randomized traffic, scored by the model inside tick().
    for (int c = 0; c < 2000; c++) begin
      rnd        = {$urandom, $urandom, $urandom};
      load_valid = ($urandom_range(0, 29) == 0);
      load_len   = 5'($urandom_range(0, 20));
      load_chars = rnd[79:0];
      pause      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      rst_n      = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_scroll_display.md
HEX_SCROLL_DISPLAY -- requirements
Module: hex_scroll_display

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, meaning the number of seven-segment digits driven.
REQ-002 The block SHALL have parameter MSG_LEN, default 16, meaning the message buffer depth in characters.
REQ-003 The block SHALL have parameter STEP_DIV, default 25_000_000, meaning clock cycles per scroll step.
REQ-004 The block SHALL have parameter BLINK_DIV, default 12_500_000, meaning clock cycles per blink phase.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port load_valid, input, 1 bit: a new message is presented.
REQ-008 Port load_ready, output, 1 bit: the block accepts a message this cycle.
REQ-009 Port load_chars, input, MSG_LEN*5 bits: 5-bit character codes, char 0 in bits [4:0], displayed first.
REQ-010 Port load_len, input, $clog2(MSG_LEN+1) bits: number of valid characters.
REQ-011 Port blink_en, input, 1 bit: enables blinking of the whole display.
REQ-012 Port pause, input, 1 bit: freezes the scroll offset and the step prescaler.
REQ-013 Port hex_out, output, NUM_DIGITS*8 bits: segment bytes; digit NUM_DIGITS-1 (leftmost) occupies the top byte.
REQ-014 Port scrolling, output, 1 bit: high while the FSM is in SCROLL.
REQ-015 Port wrap, output, 1 bit: one-cycle pulse when the scroll offset wraps to 0.

Function
REQ-016 The FSM SHALL have three states: EMPTY (all digits blank), STATIC, and SCROLL.
REQ-017 A load handshake SHALL occur on a cycle where load_valid and load_ready are both 1; load_ready SHALL be 1 in every state except the reset cycle.
REQ-018 On a handshake, the buffer SHALL capture load_chars; len SHALL be load_len, clamped to MSG_LEN.
REQ-019 On a handshake, the offset and the prescaler SHALL clear to 0 and the next state SHALL be: len=0 -> EMPTY; 1..NUM_DIGITS -> STATIC; >NUM_DIGITS -> SCROLL.
REQ-020 In STATIC, chars 0..len-1 SHALL be left-justified, with the remaining digits BLANK.
REQ-021 In SCROLL, window position i SHALL show padded[(offset+i) mod (len+NUM_DIGITS)], where padded is the message followed by NUM_DIGITS BLANKs.
REQ-022 In SCROLL, the prescaler SHALL count 0..STEP_DIV-1; at terminal count the offset SHALL increment.
REQ-023 When the offset is at len+NUM_DIGITS-1, the next step SHALL wrap it to 0 and assert wrap for exactly that cycle.
REQ-024 pause=1 SHALL hold the offset and the prescaler; a handshake during pause SHALL still be accepted and SHALL still clear both.
REQ-025 When a handshake coincides with a step, the handshake SHALL take priority: no increment and no wrap.
REQ-026 The blink counter SHALL run when blink_en=1 and toggle its phase every BLINK_DIV cycles; in the off phase all digits SHALL show BLANK.
REQ-027 When blink_en=0, the blink counter SHALL clear and the phase SHALL be on.
REQ-028 Display characters SHALL be registered; hex_out SHALL be combinational decode of the registers, so a new message appears on the cycle after the handshake.
REQ-029 Character codes SHALL be: 0-15 hex digits, 16 R, 17 d, 18 t, 19 BLANK; codes 20-31 SHALL decode as BLANK.

Reset
REQ-030 While rst_n=0 at a clock edge, the state SHALL become EMPTY and len, offset, prescaler, blink counter and phase SHALL clear.
REQ-031 After reset, all character registers SHALL be BLANK, hex_out SHALL be the BLANK segment pattern on every digit, and scrolling, wrap and load_ready SHALL be 0 for that cycle.
REQ-032 Reset asserted mid-scroll SHALL abandon the message; the block SHALL remain EMPTY until the next handshake.

Structure
REQ-033 A shared package SHALL hold the character-code constants (CHAR_R, CHAR_D, CHAR_T, BLANK, ...) and the FSM state enum.
REQ-034 Each digit SHALL be decoded by one instance of the existing hexDriver sub-module, arrayed NUM_DIGITS wide; no other sub-module SHALL be used.

Verification (NUM_DIGITS=6, MSG_LEN=16, STEP_DIV=4, BLINK_DIV=8)
REQ-035 Reset, then load len=4 chars {1,2,3,4} -> next cycle: digits 5..2 show 1,2,3,4, digits 1..0 BLANK; scrolling=0.
REQ-036 Load len=8 chars 0..7 -> scrolling=1; window advances every 4 cycles; offset 13->0 asserts wrap for 1 cycle, 56 cycles after the handshake.
REQ-037 pause=1 for 10 cycles mid-scroll -> window unchanged; stepping resumes with the prescaler value it held.
REQ-038 Handshake on a step cycle -> new message shown at offset 0; no wrap pulse.
REQ-039 blink_en=1 with a static message -> display alternates message/all-BLANK every 8 cycles; blink_en=0 -> message shown steadily.
REQ-040 load_len=0, and separately load_len=20 -> EMPTY (all BLANK); 20 is clamped to 16 and scrolls with period (16+6)*4 = 88 cycles.
